// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage owning the PC, driving the instruction ROM and
// buffering one fetched word toward the interpreter with a valid/ready handshake.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start                          pulse; (re)starts fetching at address 0 from IDLE/HALT
//   rom_en, rom_addr, rom_data     combinational ROM read (enable only on a load cycle)
//   inst, inst_pc, inst_valid      registered instruction slot
//   inst_ready                     interpreter accepts the slot this cycle
//   redirect_valid, redirect_addr  control-flow redirect
//   halted, fault                  HALT state indicator, sticky out-of-range redirect flag
//   issue_count                    accepted-instruction counter, present only with
//                                  FETCH_PERF_CNT_EN defined
module instr_fetch_unit #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 16,
    parameter int PROG_LEN = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              halted,
    output logic              fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       issue_count
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);
    // One extra bit so PROG_LEN == 2**ADDR_W is representable
    localparam logic [ADDR_W:0] LEN = (ADDR_W + 1)'(PROG_LEN);
    state_t state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, inst_pc_q, inst_pc_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic valid_q, valid_d, fault_q, fault_d;
    logic load, accept, redir_ok;
    assign accept   = valid_q && inst_ready;
    assign load     = !rst && state_q == S_RUN && !redirect_valid && (!valid_q || inst_ready);
    assign redir_ok = {1'b0, redirect_addr} < LEN;
    assign rom_en     = load;
    assign rom_addr   = pc_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = valid_q;
    assign halted     = state_q == S_HALT;
    assign fault      = fault_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            S_RUN, S_DRAIN: begin
                // Redirect wins over both load and accept; the buffered word is squashed
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    if (redir_ok) begin
                        pc_d    = redirect_addr;
                        state_d = S_RUN;
                    end else begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end
                end else if (load) begin
                    inst_d    = rom_data;
                    inst_pc_d = pc_q;
                    valid_d   = 1'b1;
                    if (pc_q == LAST_PC) state_d = S_DRAIN;
                    else pc_d = pc_q + ADDR_W'(1);
                end else if (accept) begin
                    valid_d = 1'b0;
                    state_d = state_q == S_DRAIN ? S_HALT : state_q;
                end
            end
            default: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    fault_d = 1'b0;
                end
            end
        endcase
    end
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    assign issue_count = cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    // Handshakes squashed by a same-cycle redirect are not issues
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_HALT && start) cnt_d = '0;
        else if (accept && !redirect_valid && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized checks of instr_fetch_unit against a queue-based model.
module tb_instr_fetch_unit;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int PL = 9;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, start, rom_en, inst_valid, inst_ready, redirect_valid, halted, fault;
  logic [AW-1:0] rom_addr, inst_pc, redirect_addr;
  logic [DW-1:0] rom_data, inst;
  logic [DW-1:0] rom [16];
  assign rom_data = rom[rom_addr];
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] issue_count;
`endif
  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .PROG_LEN(PL)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .halted(halted), .fault(fault)
`ifdef FETCH_PERF_CNT_EN
    , .issue_count(issue_count)
`endif
  );
  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } word_t;
  word_t m_buf[$];
  logic m_active, m_fetching, m_halted, m_fault;
  logic [AW-1:0] m_next;
  int m_cnt;
  int checks = 0;
  int failures = 0;
  int en_cycles = 0;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    if (o !== e) begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask
  function automatic logic m_rom_en();
    return !rst && m_active && m_fetching && !redirect_valid && (m_buf.size() == 0 || inst_ready);
  endfunction
  task automatic model_reset();
    m_buf.delete();
    m_active = 0;
    m_fetching = 0;
    m_halted = 0;
    m_fault = 0;
    m_next = '0;
    m_cnt = 0;
  endtask
  task automatic model_edge();
    logic took;
    took = 0;
    if (rst) model_reset();
    else if (!m_active) begin
      if (start) begin
        if (m_halted) m_cnt = 0;
        m_active = 1;
        m_fetching = 1;
        m_halted = 0;
        m_fault = 0;
        m_next = '0;
      end
    end else if (redirect_valid) begin
      m_buf.delete();
      if (int'(redirect_addr) < PL) begin
        m_next = redirect_addr;
        m_fetching = 1;
      end else begin
        m_active = 0;
        m_halted = 1;
        m_fault = 1;
      end
    end else begin
      took = m_buf.size() != 0 && inst_ready;
      if (took) begin
        void'(m_buf.pop_front());
        if (m_cnt < 65535) m_cnt++;
      end
      if (m_buf.size() == 0 && m_fetching) begin
        m_buf.push_back('{m_next, rom[m_next]});
        if (int'(m_next) == PL - 1) m_fetching = 0;
        else m_next = m_next + 1'b1;
      end else if (took && !m_fetching) begin
        m_active = 0;
        m_halted = 1;
      end
    end
  endtask
  task automatic cyc(input logic s, input logic rv, input logic [AW-1:0] ra, input logic rdy, input logic r);
    start = s;
    redirect_valid = rv;
    redirect_addr = ra;
    inst_ready = rdy;
    rst = r;
    #1;
    chk("rom_en", rom_en, m_rom_en());
    chk("rom_addr", rom_addr, m_next);
    if (rom_en === 1'b1) en_cycles++;
    @(posedge clk);
    model_edge();
    #1;
    chk("inst_valid", inst_valid, m_buf.size() != 0);
    if (m_buf.size() != 0) begin
      chk("inst", inst, m_buf[0].data);
      chk("inst_pc", inst_pc, m_buf[0].pc);
    end
    chk("halted", halted, m_halted);
    chk("fault", fault, m_fault);
`ifdef FETCH_PERF_CNT_EN
    chk("issue_count", issue_count, 16'(m_cnt));
`endif
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'h1000 + 16'(i);
    rst = 1;
    start = 0;
    redirect_valid = 0;
    redirect_addr = '0;
    inst_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("reset_inst", inst, 16'h0000);
    chk("reset_inst_pc", inst_pc, 4'h0);
    chk("reset_valid", inst_valid, 1'b0);
    chk("reset_rom_en", rom_en, 1'b0);
    chk("reset_halted", halted, 1'b0);
    chk("reset_fault", fault, 1'b0);
    cyc(0, 0, 0, 1, 0);
    en_cycles = 0;
    cyc(1, 0, 0, 1, 0);
    repeat (12) cyc(0, 0, 0, 1, 0);
    chk("straight_en_cycles", en_cycles, 9);
    chk("straight_halted", halted, 1'b1);
    cyc(1, 0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 1, 0);
    chk("stall_word", inst, 16'h1002);
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("stall_held", inst_pc, 4'h2);
    cyc(0, 0, 0, 1, 0);
    chk("stall_next", inst, 16'h1003);
    repeat (8) cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    repeat (4) cyc(0, 0, 0, 1, 0);
    chk("redir_before", inst_pc, 4'h3);
    cyc(0, 1, 4'd7, 1, 0);
    chk("redir_squash", inst_valid, 1'b0);
    cyc(0, 0, 0, 1, 0);
    chk("redir_target", inst_pc, 4'h7);
    repeat (3) cyc(0, 0, 0, 1, 0);
    chk("redir_halt", halted, 1'b1);
    cyc(1, 0, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 4'd12, 1, 0);
    chk("bad_fault", fault, 1'b1);
    chk("bad_halted", halted, 1'b1);
    cyc(1, 0, 0, 1, 0);
    chk("bad_cleared", fault, 1'b0);
    cyc(0, 0, 0, 1, 0);
    chk("bad_refetch", inst_pc, 4'h0);
    repeat (5) cyc(0, 0, 0, 1, 0);
    chk("mid_pc5", inst_pc, 4'h5);
    cyc(0, 0, 0, 1, 1);
    chk("mid_valid", inst_valid, 1'b0);
    chk("mid_pc", rom_addr, 4'h0);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("mid_refetch", inst, 16'h1000);
    repeat (3) cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 4'd3, 1, 0);
    repeat (12) cyc(0, 0, 0, 1, 0);
    chk("squash_halted", halted, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    chk("squash_count", issue_count, 16'd9);
`endif
    for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
    for (int n = 0; n < 3000; n++)
      cyc($urandom % 12 == 0, $urandom % 8 == 0, 4'($urandom % 16), $urandom % 4 != 0, $urandom % 100 == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
